uart_rx_os: RTL and testbench



---
 rtl/uart_rx_os_if.sv | 27 ++
 rtl/uart_rx_os.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os_if.sv
// Valid/ready delivery channel of the oversampling UART receiver.
// The master drives received words, the slave drives m_ready.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] m_data;
    logic                 m_parity_err;
    logic                 m_frame_err;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output m_data,
        output m_parity_err,
        output m_frame_err,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_parity_err,
        input  m_frame_err,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: parametrised oversampling UART receiver.
// Features: 3-sample majority vote, false-start rejection,
// parity and framing error flags, and a one-entry holding register
// on a valid/ready channel.
// Optional break detector: compiled in when UART_RX_BREAK_DET_EN is defined.
module uart_rx_os #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    uart_rx_os_if.master m_if,
    output logic overrun
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic break_det
`endif
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int M     = OVERSAMPLE / 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_LOAD   = 3'd5;

    // State that follows the last data bit depends on whether parity is sent.
    localparam logic [2:0] S_AFTER_DATA = (PARITY != 0) ? S_PARITY : S_STOP;

    if (DIV < 1) begin : g_err_div
        $error("uart_rx_os: CLK_FREQ / (BAUD_RATE * OVERSAMPLE) must be at least 1");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_err_os
        $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_err_db
        $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_err_par
        $error("uart_rx_os: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_err_stop
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic [2:0]           r_state;
    logic [DIV_W-1:0]     r_div;
    logic [SC_W-1:0]      r_sc;
    logic [3:0]           r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0;
    logic                 r_s1;
    logic                 r_perr;
    logic                 r_ferr;

    logic w_start_edge;
    logic w_tick;
    logic w_wrap;
    logic w_decide;
    logic w_vote;
    logic w_par_calc;
    logic w_load_ok;

    assign w_start_edge = r_rx_prev & ~r_rx_s;
    assign w_tick       = (r_state != S_IDLE) && (r_div == DIV_W'(DIV - 1));
    assign w_wrap       = w_tick && (r_sc == SC_W'(OVERSAMPLE - 1));
    assign w_decide     = w_tick && (r_sc == SC_W'(M + 1));
    // Majority of the samples at sc = M-1, M and the live sample at sc = M+1.
    assign w_vote       = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
    // XOR of data bits and received parity bit: 1 means an odd count of ones.
    assign w_par_calc   = (^r_shift) ^ w_vote;
    assign w_load_ok    = !m_if.m_valid || m_if.m_ready;

    // Two-flop synchroniser for rx plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // Sample-tick divider: parked at 0 in IDLE so it restarts on the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_state == S_IDLE) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Frame FSM with sample counter, vote capture and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sc     <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_s0     <= 1'b0;
            r_s1     <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            if (w_tick) begin
                r_sc <= (r_sc == SC_W'(OVERSAMPLE - 1)) ? '0 : r_sc + 1'b1;
            end
            if (w_tick && (r_sc == SC_W'(M - 1))) begin
                r_s0 <= r_rx_s;
            end
            if (w_tick && (r_sc == SC_W'(M))) begin
                r_s1 <= r_rx_s;
            end
            case (r_state)
                S_IDLE: begin
                    r_sc <= '0;
                    if (w_start_edge) begin
                        r_state  <= S_START;
                        r_bitcnt <= '0;
                        r_perr   <= 1'b0;
                        r_ferr   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_decide && w_vote) begin
                        r_state <= S_IDLE;
                    end else if (w_wrap) begin
                        r_state  <= S_DATA;
                        r_bitcnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift  <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    if (w_wrap && (r_bitcnt == 4'(DATA_BITS))) begin
                        r_state  <= S_AFTER_DATA;
                        r_bitcnt <= '0;
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_perr <= (PARITY == 1) ? ~w_par_calc : w_par_calc;
                    end
                    if (w_wrap) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        r_ferr <= r_ferr | ~w_vote;
                        if (r_bitcnt == 4'(STOP_BITS - 1)) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Holding register: load a finished frame if free or being drained, else flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_if.m_data       <= '0;
            m_if.m_parity_err <= 1'b0;
            m_if.m_frame_err  <= 1'b0;
            m_if.m_valid      <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (m_if.m_valid && m_if.m_ready) begin
                m_if.m_valid <= 1'b0;
            end
            if (r_state == S_LOAD) begin
                if (w_load_ok) begin
                    m_if.m_data       <= r_shift;
                    m_if.m_parity_err <= r_perr;
                    m_if.m_frame_err  <= r_ferr;
                    m_if.m_valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    // Break: all-zero frame with a low stop bit and the line still low; held until rx_s is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            break_det <= 1'b0;
        end else if ((r_state == S_LOAD) && (r_shift == '0) && r_ferr && !r_rx_s) begin
            break_det <= 1'b1;
        end else if (r_rx_s) begin
            break_det <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os.
// Three instances: A = 8N1, B = 8E1, C = 7N2, all at 115200 baud from 50 MHz, x16.
// Expected frames go into per-instance scoreboard queues when driven and are
// popped by a negedge monitor whenever a word is accepted.
`timescale 1ns/1ps
module tb_uart_rx_os;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = DIV * OS;
    // Clocks from rx change to m_valid visible in an 8N1 frame:
    // 2 synchroniser flops + edge register, decision tick of the stop bit
    // (bit 9, sc = M+1 -> tick number 9*OS + M + 2), then one clk into LOAD.
    localparam int LAT_8N1  = 3 + (9 * OS + OS / 2 + 2) * DIV + 1;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       par;
        logic       stopv;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rx_vec;
    logic [2:0] rdy;
    logic       ovr_a, ovr_b, ovr_c;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk_a, brk_b, brk_c;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int rx_count [3];
    int ovr_cnt_a = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t sb_c[$];

    uart_rx_os_if #(.DATA_BITS(8)) if_a ();
    uart_rx_os_if #(.DATA_BITS(8)) if_b ();
    uart_rx_os_if #(.DATA_BITS(7)) if_c ();

    assign if_a.m_ready = rdy[0];
    assign if_b.m_ready = rdy[1];
    assign if_c.m_ready = rdy[2];

    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_vec[0]), .m_if(if_a.master), .overrun(ovr_a)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(brk_a)
`endif
    );

    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_vec[1]), .m_if(if_b.master), .overrun(ovr_b)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(brk_b)
`endif
    );

    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .rx(rx_vec[2]), .m_if(if_c.master), .overrun(ovr_c)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(brk_c)
`endif
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe;
        case (idx)
            0: sb_a.push_back(e);
            1: sb_b.push_back(e);
            default: sb_c.push_back(e);
        endcase
    endtask

    task automatic frame_seen(input int idx, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        int   qsize;
        rx_count[idx]++;
        $display("dut%0d word data=0x%0h perr=%b ferr=%b", idx, d, pe, fe);
        case (idx)
            0: qsize = sb_a.size();
            1: qsize = sb_b.size();
            default: qsize = sb_c.size();
        endcase
        if (qsize == 0) begin
            check($sformatf("unexpected_word_dut%0d", idx), {23'd0, d}, 32'hFFFF_FFFF);
        end else begin
            case (idx)
                0: e = sb_a.pop_front();
                1: e = sb_b.pop_front();
                default: e = sb_c.pop_front();
            endcase
            check($sformatf("data_dut%0d", idx), {23'd0, d}, {23'd0, e.data});
            check($sformatf("perr_dut%0d", idx), {31'd0, pe}, {31'd0, e.perr});
            check($sformatf("ferr_dut%0d", idx), {31'd0, fe}, {31'd0, e.ferr});
        end
    endtask

    // Scoreboard monitor: an accept is m_valid && m_ready seen mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (if_a.m_valid && if_a.m_ready)
                frame_seen(0, {1'b0, if_a.m_data}, if_a.m_parity_err, if_a.m_frame_err);
            if (if_b.m_valid && if_b.m_ready)
                frame_seen(1, {1'b0, if_b.m_data}, if_b.m_parity_err, if_b.m_frame_err);
            if (if_c.m_valid && if_c.m_ready)
                frame_seen(2, {2'b0, if_c.m_data}, if_c.m_parity_err, if_c.m_frame_err);
            if (ovr_a) ovr_cnt_a++;
        end
    end

    task automatic send_bit(input int idx, input logic v);
        rx_vec[idx] = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    // Caller is aligned at posedge+1; returns at posedge+1 after the last stop bit.
    task automatic send_frame(input int idx, input logic [8:0] d, input int nbits,
                              input bit par_en, input logic par, input int nstop,
                              input logic stopv);
        send_bit(idx, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(idx, d[i]);
        if (par_en) send_bit(idx, par);
        for (int i = 0; i < nstop; i++) send_bit(idx, stopv);
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0: return sb_a.size();
            1: return sb_b.size();
            default: return sb_c.size();
        endcase
    endfunction

    // Hard bound on the run.
    initial begin
        #(95000 * 20);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        int   n;
        int   cnt;
        int   ovr0;

        vecs[0] = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h081, 1'b0, 1'b0, 9'h081, 1'b0, 1'b1};
        vecs[2] = '{1, 9'h003, 1'b1, 1'b1, 9'h003, 1'b1, 1'b0};
        vecs[3] = '{1, 9'h003, 1'b0, 1'b1, 9'h003, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h007, 1'b0, 1'b1, 9'h007, 1'b1, 1'b0};

        rx_count[0] = 0; rx_count[1] = 0; rx_count[2] = 0;
        rst_n  = 1'b0;
        rx_vec = 3'b111;
        rdy    = 3'b011;
        repeat (5) @(posedge clk);
        #1;
        check("reset_valid_a", {31'd0, if_a.m_valid}, 32'd0);
        check("reset_data_a", {24'd0, if_a.m_data}, 32'd0);
        check("reset_overrun_a", {31'd0, ovr_a}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_state_a", {if_a.m_data, if_a.m_parity_err, if_a.m_frame_err, if_a.m_valid}, 32'd0);
`ifdef UART_RX_BREAK_DET_EN
        check("reset_break_a", {31'd0, brk_a}, 32'd0);
`endif

        // 8N1 0xA5 with exact latency from start edge to m_valid.
        push(0, 9'h0A5, 1'b0, 1'b0);
        fork
            send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                n = 0;
                while (n < LAT_8N1 + BIT) begin
                    @(posedge clk);
                    n++;
                    #1;
                    if (if_a.m_valid) break;
                end
                check("latency_8n1", n, LAT_8N1);
            end
        join
        check("drained_a5", qsize(0), 0);

        // Table-driven frames on A (8N1) and B (8E1).
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].dut, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
            send_frame(vecs[i].dut, vecs[i].data, 8, vecs[i].dut == 1, vecs[i].par, 1, vecs[i].stopv);
            check($sformatf("drained_vec%0d", i), qsize(vecs[i].dut), 0);
            if (!vecs[i].stopv) send_bit(vecs[i].dut, 1'b1);
        end

        // False start: 4 ticks low, then a normal 0x3C.
        cnt = rx_count[0];
        rx_vec[0] = 1'b0;
        repeat (4 * DIV) @(posedge clk);
        #1;
        rx_vec[0] = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        check("false_start_valid", {31'd0, if_a.m_valid}, 32'd0);
        check("false_start_count", rx_count[0], cnt);
        push(0, 9'h03C, 1'b0, 1'b0);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        check("drained_3c", qsize(0), 0);

        // Break: 0x00 with low stop, line held low 20 bit times.
        cnt = rx_count[0];
        push(0, 9'h000, 1'b0, 1'b1);
        send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b0);
`ifdef UART_RX_BREAK_DET_EN
        check("break_set", {31'd0, brk_a}, 32'd1);
`endif
        repeat (20 * BIT) @(posedge clk);
        #1;
        check("break_single_frame", rx_count[0], cnt + 1);
        check("drained_break", qsize(0), 0);
        rx_vec[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
`ifdef UART_RX_BREAK_DET_EN
        check("break_held_until_rx_s", {31'd0, brk_a}, 32'd1);
`endif
        @(posedge clk); #1;
`ifdef UART_RX_BREAK_DET_EN
        check("break_cleared", {31'd0, brk_a}, 32'd0);
`endif
        send_bit(0, 1'b1);

        // Overrun: consumer stalled, 0x11 then 0x22 back-to-back.
        rdy[0] = 1'b0;
        cnt  = rx_count[0];
        ovr0 = ovr_cnt_a;
        push(0, 9'h011, 1'b0, 1'b0);
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        check("overrun_pulses", ovr_cnt_a - ovr0, 1);
        check("overrun_hold_data", {24'd0, if_a.m_data}, 32'h11);
        check("overrun_hold_valid", {31'd0, if_a.m_valid}, 32'd1);
        check("overrun_no_accept", rx_count[0], cnt);
        rdy[0] = 1'b1;
        @(posedge clk); #1;
        check("accept_valid_falls", {31'd0, if_a.m_valid}, 32'd0);
        check("accept_count", rx_count[0], cnt + 1);
        check("drained_overrun", qsize(0), 0);

        // 7N2 on C: hold a word, reset mid-frame, then receive 0x5A.
        send_frame(2, 9'h02B, 7, 1'b0, 1'b0, 2, 1'b1);
        check("c_hold_valid", {31'd0, if_c.m_valid}, 32'd1);
        check("c_hold_data", {25'd0, if_c.m_data}, 32'h2B);
        send_bit(2, 1'b0);
        send_bit(2, 1'b0);
        send_bit(2, 1'b1);
        send_bit(2, 1'b0);
        rx_vec[2] = 1'b1;
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        check("c_reset_outputs", {if_c.m_data, if_c.m_parity_err, if_c.m_frame_err, if_c.m_valid, ovr_c}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy[2] = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        check("c_idle_after_reset", rx_count[2], 0);
        push(2, 9'h05A, 1'b0, 1'b0);
        send_frame(2, 9'h05A, 7, 1'b0, 1'b0, 2, 1'b1);
        check("drained_5a", qsize(2), 0);
        check("c_count", rx_count[2], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
